// File: rtl/sdr_hist_pkg.sv
// Shared constants and scanner state type for the 3x3 histogram datapath.
package sdr_hist_pkg;

  localparam int NUM_BINS  = 9;
  localparam int BIN_W     = 9;
  localparam int SUM_W     = 13;
  localparam int BIN_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } scan_state_e;

endpackage

// File: rtl/matrix_peak_scanner.sv
// Snapshots nine histogram bins, scans them one per cycle for the largest and
// second-largest values plus their sum, and holds the result for a consumer.
module matrix_peak_scanner
  import sdr_hist_pkg::*;
#(
  parameter int PEAK_THRESH = 16,
  parameter int MARGIN      = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [NUM_BINS-1:0][BIN_W-1:0]     matrix,
  output logic                               busy,
  output logic                               result_valid,
  input  logic                               result_ready,
  output logic [BIN_IDX_W-1:0]               peak_bin,
  output logic [BIN_W-1:0]                   peak_count,
  output logic [BIN_W-1:0]                   second_count,
  output logic [SUM_W-1:0]                   total_count,
  output logic                               lock
);

  localparam logic [BIN_IDX_W-1:0] LAST_IDX = BIN_IDX_W'(NUM_BINS - 1);
  localparam logic [BIN_W-1:0]     THRESH_C = BIN_W'(PEAK_THRESH);
  localparam logic [BIN_W-1:0]     MARGIN_C = BIN_W'(MARGIN);

  scan_state_e                       state_q,    state_d;
  logic [BIN_IDX_W-1:0]              idx_q,      idx_d;
  logic [NUM_BINS-1:0][BIN_W-1:0]    snap_q,     snap_d;
  logic [BIN_W-1:0]                  peak_q,     peak_d;
  logic [BIN_W-1:0]                  second_q,   second_d;
  logic [BIN_IDX_W-1:0]              peak_bin_q, peak_bin_d;
  logic [SUM_W-1:0]                  total_q,    total_d;
  logic                              busy_q,     busy_d;
  logic                              valid_q,    valid_d;
  logic [BIN_W-1:0]                  bin_s;

  assign bin_s = snap_q[idx_q];

  // Next-state, snapshot capture and the per-bin compare/accumulate step.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    snap_d     = snap_q;
    peak_d     = peak_q;
    second_d   = second_q;
    peak_bin_d = peak_bin_q;
    total_d    = total_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          snap_d     = matrix;
          idx_d      = '0;
          peak_d     = '0;
          second_d   = '0;
          peak_bin_d = '0;
          total_d    = '0;
          state_d    = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        // Strict '>' keeps the lower index on a tie and demotes the tie to second.
        if (bin_s > peak_q) begin
          second_d   = peak_q;
          peak_d     = bin_s;
          peak_bin_d = idx_q;
        end else if (bin_s > second_q) begin
          second_d = bin_s;
        end else begin
          second_d = second_q;
        end
        total_d = total_q + SUM_W'(bin_s);
        if (idx_q == LAST_IDX) begin
          state_d = HOLD;
        end else begin
          idx_d = idx_q + {{(BIN_IDX_W-1){1'b0}}, 1'b1};
        end
      end
      HOLD: begin
        if (result_ready) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d  = (state_d == SCAN);
    valid_d = (state_d == HOLD);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      snap_q     <= '0;
      peak_q     <= '0;
      second_q   <= '0;
      peak_bin_q <= '0;
      total_q    <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      snap_q     <= snap_d;
      peak_q     <= peak_d;
      second_q   <= second_d;
      peak_bin_q <= peak_bin_d;
      total_q    <= total_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
    end
  end

  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign peak_bin     = peak_bin_q;
  assign peak_count   = peak_q;
  assign second_count = second_q;
  assign total_count  = total_q;
  // second never exceeds peak, so the difference cannot wrap.
  assign lock         = (peak_q >= THRESH_C) && ((peak_q - second_q) >= MARGIN_C);

endmodule

// File: tb/tb_matrix_peak_scanner.sv
// Directed bench for matrix_peak_scanner: stimulus pushes expected results into
// a queue, a negedge monitor pops and compares whenever result_valid is high.
module tb_matrix_peak_scanner;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic [8:0][8:0]      matrix;
  logic                 busy;
  logic                 result_valid;
  logic                 result_ready;
  logic [3:0]           peak_bin;
  logic [8:0]           peak_count;
  logic [8:0]           second_count;
  logic [12:0]          total_count;
  logic                 lock;

  typedef struct {
    logic [3:0]  pb;
    logic [8:0]  pk;
    logic [8:0]  sc;
    logic [12:0] tot;
    logic        lk;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   have_exp;
  bit   prev_v;
  int   tests;
  int   fails;
  int   v[9];

  matrix_peak_scanner #(.PEAK_THRESH(16), .MARGIN(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .matrix       (matrix),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .peak_bin     (peak_bin),
    .peak_count   (peak_count),
    .second_count (second_count),
    .total_count  (total_count),
    .lock         (lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input int pb, input int pk, input int sc, input int tot, input int lk);
    exp_t e;
    e.pb  = 4'(pb);
    e.pk  = 9'(pk);
    e.sc  = 9'(sc);
    e.tot = 13'(tot);
    e.lk  = 1'(lk);
    return e;
  endfunction

  task automatic load_v();
    for (int k = 0; k < 9; k++) matrix[k] = 9'(v[k]);
  endtask

  // Scoreboard monitor: pop on the first valid cycle, compare on every valid cycle.
  always @(negedge clk) begin
    if (result_valid) begin
      if (!prev_v) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          have_exp = 1'b0;
          $display("FAIL unexpected_valid: got result_valid=1 expected no pending result at %0t", $time);
        end else begin
          cur      = exp_q.pop_front();
          have_exp = 1'b1;
        end
      end
      if (have_exp) begin
        chk("peak_bin",     32'(peak_bin),     32'(cur.pb));
        chk("peak_count",   32'(peak_count),   32'(cur.pk));
        chk("second_count", 32'(second_count), 32'(cur.sc));
        chk("total_count",  32'(total_count),  32'(cur.tot));
        chk("lock",         32'(lock),         32'(cur.lk));
      end
    end
    prev_v = result_valid;
  end

  // One full scan from v[]; disturb perturbs matrix/start mid-scan and in HOLD.
  task automatic run_scan(input exp_t e, input bit disturb, input int hold_cycles);
    load_v();
    start = 1'b1;
    exp_q.push_back(e);
    tick();
    for (int c = 1; c <= 9; c++) begin
      if (disturb && c == 3) begin
        for (int k = 0; k < 9; k++) matrix[k] = 9'd511;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      chk("busy_in_scan", 32'(busy), 32'd1);
      chk("no_valid_in_scan", 32'(result_valid), 32'd0);
      tick();
    end
    start = 1'b0;
    chk("valid_at_c10", 32'(result_valid), 32'd1);
    chk("busy_off_hold", 32'(busy), 32'd0);
    if (disturb) begin
      start = 1'b1;
      for (int h = 0; h < hold_cycles; h++) begin
        tick();
        start = 1'b0;
        chk("valid_held", 32'(result_valid), 32'd1);
        chk("busy_held", 32'(busy), 32'd0);
      end
      start = 1'b1;
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    start        = 1'b0;
    chk("idle_valid_low", 32'(result_valid), 32'd0);
    chk("idle_busy_low", 32'(busy), 32'd0);
    tick();
    chk("start_not_queued", 32'(busy), 32'd0);
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    have_exp     = 1'b0;
    prev_v       = 1'b0;
    rst_n        = 1'b0;
    start        = 1'b0;
    result_ready = 1'b0;
    matrix       = '0;
    tick();
    tick();
    chk("rst_busy",   32'(busy),         32'd0);
    chk("rst_valid",  32'(result_valid), 32'd0);
    chk("rst_pb",     32'(peak_bin),     32'd0);
    chk("rst_peak",   32'(peak_count),   32'd0);
    chk("rst_second", 32'(second_count), 32'd0);
    chk("rst_total",  32'(total_count),  32'd0);
    chk("rst_lock",   32'(lock),         32'd0);
    rst_n = 1'b1;
    tick();

    v = '{0, 3, 0, 0, 50, 2, 0, 1, 0};
    run_scan(mk(4, 50, 3, 56, 1), 1'b0, 0);
    v = '{7, 7, 7, 7, 7, 7, 7, 7, 7};
    run_scan(mk(0, 7, 7, 63, 0), 1'b0, 0);
    v = '{16, 20, 0, 0, 0, 0, 0, 0, 0};
    run_scan(mk(1, 20, 16, 36, 1), 1'b0, 0);
    v = '{0, 0, 17, 0, 0, 20, 0, 0, 0};
    run_scan(mk(5, 20, 17, 37, 0), 1'b0, 0);
    v = '{15, 0, 0, 0, 0, 0, 0, 0, 0};
    run_scan(mk(0, 15, 0, 15, 0), 1'b0, 0);
    v = '{10, 20, 30, 40, 50, 60, 70, 80, 100};
    run_scan(mk(8, 100, 80, 460, 1), 1'b1, 5);
    v = '{511, 511, 511, 511, 511, 511, 511, 511, 511};
    run_scan(mk(0, 511, 511, 4599, 0), 1'b0, 0);
    v = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_scan(mk(0, 0, 0, 0, 0), 1'b0, 0);

    // Reset in the fifth SCAN cycle; nothing is pushed, so any later valid is flagged.
    v = '{40, 1, 2, 3, 4, 5, 6, 7, 8};
    load_v();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    chk("busy_before_abort", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy",   32'(busy),         32'd0);
    chk("abort_valid",  32'(result_valid), 32'd0);
    chk("abort_pb",     32'(peak_bin),     32'd0);
    chk("abort_peak",   32'(peak_count),   32'd0);
    chk("abort_second", 32'(second_count), 32'd0);
    chk("abort_total",  32'(total_count),  32'd0);
    chk("abort_lock",   32'(lock),         32'd0);
    for (int c = 0; c < 15; c++) begin
      tick();
      chk("no_valid_after_abort", 32'(result_valid), 32'd0);
    end
    v = '{0, 3, 0, 0, 50, 2, 0, 1, 0};
    run_scan(mk(4, 50, 3, 56, 1), 1'b0, 0);

    tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
